// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// seq_divider : iterative restoring divider (DIV/DIVU), one quotient bit/cycle
// Revision    : 1.0
// ============================================================================
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               sq_q, sq_d;
  logic               sr_q, sr_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH:0]     r_sh;
  logic [WIDTH-1:0]   r_sub;
  logic               fits;
  logic               accept;

  // The partial remainder after a successful subtract is always below the
  // divisor, so only WIDTH bits need to be kept between cycles.
  assign r_sh   = {rem_q, quo_q[WIDTH-1]};
  assign fits   = (r_sh >= {1'b0, dvs_q});
  assign r_sub  = r_sh[WIDTH-1:0] - dvs_q;
  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    sq_d        = sq_q;
    sr_d        = sr_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          state_d = CALC;
          cnt_d   = CNT_W'(WIDTH - 1);
          rem_d   = '0;
          quo_d   = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
          dvs_d   = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
          sq_d    = signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          sr_d    = signed_op && dividend[WIDTH-1];
          zero_d  = (divisor == '0);
        end
      end
      CALC: begin
        rem_d = fits ? r_sub : r_sh[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], fits};
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIX: begin
        state_d = DONE;
        // Zero divisor leaves R equal to |dividend|, which the sign fix maps
        // back to the original dividend; only the quotient needs forcing.
        quotient_d  = zero_q ? '1 : (sq_q ? -quo_q : quo_q);
        remainder_d = sr_q ? -rem_q : rem_q;
        dbz_d       = zero_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      sq_q        <= 1'b0;
      sr_q        <= 1'b0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      sq_q        <= sq_d;
      sr_q        <= sr_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == CALC) || (state_q == FIX);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// tb_seq_divider : directed + random checks of seq_divider against arithmetic
// Revision       : 1.0
// ============================================================================
module tb_seq_divider;

  localparam int WIDTH   = 32;
  localparam int LAT     = WIDTH + 2;
  localparam int MAX_CYC = 80;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division in 64 bits, with the divide-by-zero rule.
  task automatic model(input logic s, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, output logic [WIDTH-1:0] q,
                       output logic [WIDTH-1:0] r, output logic z);
    longint sa, sb;
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      q = WIDTH'(sa / sb);
      r = WIDTH'(sa % sb);
      z = 1'b0;
    end
  endtask

  task automatic drive_start(input logic s, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b);
    start     = 1'b1;
    signed_op = s;
    dividend  = a;
    divisor   = b;
    tick();
    start     = 1'b0;
  endtask

  // Called right after the accepting edge; returns once done is seen.
  task automatic wait_done(input string tag);
    int edges;
    int busy_cyc;
    edges    = 1;
    busy_cyc = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && edges < MAX_CYC) begin
      tick();
      edges++;
      if (busy === 1'b1) busy_cyc++;
    end
    check({tag, "_latency"}, WIDTH'(edges), WIDTH'(LAT));
    check({tag, "_busy_cycles"}, WIDTH'(busy_cyc), WIDTH'(WIDTH + 1));
    check({tag, "_busy_in_done"}, {31'd0, busy}, '0);
  endtask

  task automatic check_result(input string tag, input logic [WIDTH-1:0] eq,
                              input logic [WIDTH-1:0] er, input logic ez);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
  endtask

  task automatic run(input string tag, input logic s, input logic [WIDTH-1:0] a,
                     input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] eq,
                     input logic [WIDTH-1:0] er, input logic ez);
    drive_start(s, a, b);
    wait_done(tag);
    check_result(tag, eq, er, ez);
    tick();
    check({tag, "_done_pulse"}, {31'd0, done}, '0);
    check({tag, "_hold_q"}, quotient, eq);
  endtask

  initial begin
    logic [WIDTH-1:0] a, b, eq, er;
    logic             ez, s;
    int               saw_done;

    rst = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset_busy", {31'd0, busy}, '0);
    check("reset_done", {31'd0, done}, '0);
    check_result("reset", '0, '0, 1'b0);

    run("u100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
    run("s-7_2",    1'b1, 32'hFFFFFFF9,   32'h00000002,   32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0);
    run("s7_-2",    1'b1, 32'h00000007,   32'hFFFFFFFE,   32'hFFFFFFFD,   32'h00000001,   1'b0);
    run("u5_0",     1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1);
    run("s5_0",     1'b1, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1);
    run("u9_3",     1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0);
    run("s-5_0",    1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1);
    run("s_ovf",    1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0);
    run("u_max_1",  1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0);

    // A start during CALC must be ignored.
    drive_start(1'b0, 32'd20, 32'd3);
    tick(); tick(); tick();
    start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    tick();
    start = 1'b0;
    check("ign_busy", {31'd0, busy}, 32'd1);
    while (done !== 1'b1 && saw_done < MAX_CYC) begin
      tick();
      saw_done++;
    end
    check("ign_done_seen", {31'd0, done}, 32'd1);
    check_result("ign", 32'd6, 32'd2, 1'b0);

    // Back-to-back: accepted in the DONE cycle.
    drive_start(1'b0, 32'd50, 32'd5);
    check("b2b_done_low", {31'd0, done}, '0);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_hold_q", quotient, 32'd6);
    wait_done("b2b");
    check_result("b2b", 32'd10, 32'd0, 1'b0);
    tick();

    // Reset in the 10th CALC cycle aborts the operation.
    drive_start(1'b0, 32'd100, 32'd7);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, '0);
    check("abort_done", {31'd0, done}, '0);
    check_result("abort", '0, '0, 1'b0);
    saw_done = 0;
    repeat (LAT + 4) begin
      tick();
      if (done === 1'b1) saw_done++;
    end
    check("abort_no_done", WIDTH'(saw_done), '0);
    run("u9_4", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF;
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      model(s, a, b, eq, er, ez);
      run($sformatf("rnd%0d", i), s, a, b, eq, er, ez);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
